// File: rtl/fp_sp_pkg.sv
// Shared IEEE-754 single-precision field layout, integer limits and converter states.
package fp_sp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_W   = 23;

    localparam logic [7:0] EXP_BIAS    = 8'd127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

endpackage

// File: rtl/fp_sp_to_int32_if.sv
// Valid/ready request and response bundle of the float-to-int32 converter.
interface fp_sp_to_int32_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, round_mode, out_ready,
        input  in_ready, out_valid, out_data, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_data, round_mode, out_ready,
        output in_ready, out_valid, out_data, out_invalid, out_inexact
    );

endinterface

// File: rtl/fp_sp_unpack.sv
// Combinational single-precision decoder: fields, class flags and the
// alignment shift that brings the mantissa binary point onto bit 0.
module fp_sp_unpack
    import fp_sp_pkg::*;
(
    input  logic               [31:0] data,
    output logic                      sign,
    output logic               [23:0] m,
    output logic signed         [9:0] e,
    output logic                      is_nan,
    output logic                      is_inf,
    output logic                      is_zero,
    output logic                      shl,
    output logic                [4:0] s
);

    logic [7:0]        expf;
    logic [FRAC_W-1:0] frac;

    assign expf = data[EXP_MSB:EXP_LSB];
    assign frac = data[FRAC_W-1:0];

    // Decode; the shift is only nonzero where the integer part fits the datapath.
    always_comb begin
        sign    = data[SIGN_BIT];
        m       = (expf == 8'd0) ? 24'd0 : {1'b1, frac};
        e       = $signed({2'b00, expf}) - $signed({2'b00, EXP_BIAS});
        is_nan  = (expf == EXP_SPECIAL) && (frac != '0);
        is_inf  = (expf == EXP_SPECIAL) && (frac == '0);
        is_zero = (expf == 8'd0) && (frac == '0);
        shl     = 1'b0;
        s       = 5'd0;
        if (expf != EXP_SPECIAL) begin
            if (e >= 10'sd0 && e <= 10'sd23) begin
                s = 5'(10'sd23 - e);
            end else if (e >= 10'sd24 && e <= 10'sd30) begin
                shl = 1'b1;
                s   = 5'(e - 10'sd23);
            end
        end
    end

endmodule

// File: rtl/fp_sp_to_int32.sv
// Iterative single-precision to int32 converter. The mantissa is aligned STEP
// bits per cycle, then rounded/saturated once and held until the consumer takes it.
module fp_sp_to_int32
    import fp_sp_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    fp_sp_to_int32_if.slave   bus
);

    localparam logic [4:0] STEP_S = 5'(STEP);

    // Decoded view of the incoming operand, only consumed on the accept cycle.
    logic               u_sign, u_nan, u_inf, u_zero, u_shl;
    logic        [23:0] u_m;
    logic signed  [9:0] u_e;
    logic         [4:0] u_s;

    fp_sp_unpack u_unpack (
        .data    (bus.in_data),
        .sign    (u_sign),
        .m       (u_m),
        .e       (u_e),
        .is_nan  (u_nan),
        .is_inf  (u_inf),
        .is_zero (u_zero),
        .shl     (u_shl),
        .s       (u_s)
    );

    state_t             state;
    logic               sign_q, rm_q, shl_q, special_q, nan_q, zero_q, frac_nz_q;
    logic               guard_q, sticky_q;
    logic signed  [9:0] e_q;
    logic         [4:0] s_q;
    logic        [31:0] mag_q;

    logic               in_ready_q, out_valid_q, out_invalid_q, out_inexact_q;
    logic        [31:0] out_data_q;

    // One alignment step: distance, shifted mantissa and the bits that fall off.
    logic        [4:0] k, k_m1;
    logic       [31:0] mag_sh;
    logic              guard_n, sticky_n;

    always_comb begin
        k        = (s_q > STEP_S) ? STEP_S : s_q;
        k_m1     = k - 5'd1;
        guard_n  = |(mag_q & (32'd1 << k_m1));
        sticky_n = sticky_q | guard_q | (|(mag_q & ((32'd1 << k_m1) - 32'd1)));
        mag_sh   = shl_q ? (mag_q << k) : (mag_q >> k);
    end

    // Final result: specials and out-of-range saturate, tiny values round to 0/1,
    // in-range values take the round-to-nearest-even increment, then apply sign.
    logic [31:0] mag_rnd, res;
    logic        res_inv, res_inx;

    always_comb begin
        mag_rnd = mag_q;
        res     = 32'd0;
        res_inv = 1'b0;
        res_inx = 1'b0;
        if (special_q) begin
            res_inv = 1'b1;
            res     = (nan_q || !sign_q) ? INT32_MAX : INT32_MIN;
        end else if (e_q >= 10'sd31) begin
            if (sign_q && e_q == 10'sd31 && !frac_nz_q) begin
                res = INT32_MIN;
            end else begin
                res_inv = 1'b1;
                res     = sign_q ? INT32_MIN : INT32_MAX;
            end
        end else begin
            if (e_q < 10'sd0) begin
                mag_rnd = (rm_q && e_q == -10'sd1 && frac_nz_q) ? 32'd1 : 32'd0;
                res_inx = !zero_q;
            end else if (!shl_q) begin
                mag_rnd = mag_q + {31'd0, rm_q & guard_q & (sticky_q | mag_q[0])};
                res_inx = guard_q | sticky_q;
            end
            res = sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
        end
    end

    // Control FSM and datapath registers; all handshake outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sign_q        <= 1'b0;
            rm_q          <= 1'b0;
            shl_q         <= 1'b0;
            special_q     <= 1'b0;
            nan_q         <= 1'b0;
            zero_q        <= 1'b0;
            frac_nz_q     <= 1'b0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            e_q           <= '0;
            s_q           <= '0;
            mag_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q     <= u_sign;
                        rm_q       <= bus.round_mode;
                        shl_q      <= u_shl;
                        special_q  <= u_nan | u_inf;
                        nan_q      <= u_nan;
                        zero_q     <= u_zero;
                        frac_nz_q  <= (bus.in_data[FRAC_W-1:0] != '0);
                        guard_q    <= 1'b0;
                        sticky_q   <= 1'b0;
                        e_q        <= u_e;
                        s_q        <= u_s;
                        mag_q      <= {8'd0, u_m};
                        in_ready_q <= 1'b0;
                        state      <= (u_s != 5'd0) ? ALIGN : ROUND;
                    end
                end
                ALIGN: begin
                    mag_q <= mag_sh;
                    s_q   <= s_q - k;
                    if (!shl_q) begin
                        guard_q  <= guard_n;
                        sticky_q <= sticky_n;
                    end
                    if (s_q == k) state <= ROUND;
                end
                ROUND: begin
                    out_data_q    <= res;
                    out_invalid_q <= res_inv;
                    out_inexact_q <= res_inx;
                    out_valid_q   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_invalid = out_invalid_q;
    assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_sp_to_int32.sv
// Scoreboard bench for fp_sp_to_int32: STEP=8 and STEP=1 instances share stimulus.
module tb_fp_sp_to_int32;

    typedef struct packed {
        logic [31:0] d;
        logic        inv;
        logic        inx;
    } exp_t;

    typedef struct packed {
        logic [31:0] din;
        logic        rm;
        logic [31:0] q;
        logic        inv;
        logic        inx;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        round_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = 32'd0;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    logic [31:0] got_d;
    logic        got_i, got_x;

    always #5 clk = ~clk;

    fp_sp_to_int32_if b8();
    fp_sp_to_int32_if b1();

    assign b8.in_valid   = in_valid & ~sel;
    assign b1.in_valid   = in_valid & sel;
    assign b8.in_data    = in_data;
    assign b1.in_data    = in_data;
    assign b8.round_mode = round_mode;
    assign b1.round_mode = round_mode;
    assign b8.out_ready  = out_ready;
    assign b1.out_ready  = out_ready;

    fp_sp_to_int32 #(.STEP(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
    fp_sp_to_int32 #(.STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    wire        ir = sel ? b1.in_ready    : b8.in_ready;
    wire        ov = sel ? b1.out_valid   : b8.out_valid;
    wire [31:0] od = sel ? b1.out_data    : b8.out_data;
    wire        oi = sel ? b1.out_invalid : b8.out_invalid;
    wire        ox = sel ? b1.out_inexact : b8.out_inexact;

    // Reference latency: 1 ROUND cycle plus ceil(s/STEP) alignment cycles.
    function automatic int exp_lat(input logic [31:0] d, input int step);
        int ex, e, s;
        ex = int'(d[30:23]);
        e  = ex - 127;
        s  = 0;
        if (ex != 255 && e >= 0 && e <= 23) s = 23 - e;
        if (ex != 255 && e >= 24 && e <= 30) s = e - 23;
        return 1 + (s + step - 1) / step;
    endfunction

    // Offer one operand, wait for the result, capture it, then let it drain.
    task automatic xfer(input logic [31:0] d, input logic rm, output int lat);
        @(negedge clk);
        in_data    = d;
        round_mode = rm;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!ov && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_d = od;
        got_i = oi;
        got_x = ox;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        #12;
        checks++; if (ir !== 1'b1)      begin errors++; $display("FAIL reset_in_ready got=%b want=1", ir); end
        checks++; if (ov !== 1'b0)      begin errors++; $display("FAIL reset_out_valid got=%b want=0", ov); end
        checks++; if (od !== 32'd0)     begin errors++; $display("FAIL reset_out_data got=%h want=0", od); end
        checks++; if ({oi, ox} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {oi, ox}); end
        @(negedge clk);
        reset = 1'b1;
        // Abort a 1.0 conversion while it is still aligning.
        @(negedge clk);
        in_data = 32'h3F80_0000; round_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (ir !== 1'b0) begin errors++; $display("FAIL accept_in_ready got=%b want=0", ir); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (ir !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL midalign_reset in_ready=%b out_valid=%b want 1/0", ir, ov);
        end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL reset_no_partial got=%0d valid cycles want=0", n); end
    endtask

    task automatic test_values();
        vec_t tbl [0:21];
        exp_t ex;
        int lat;
        tbl = '{
            '{32'h3FC0_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b1},
            '{32'h3FC0_0000, 1'b1, 32'h0000_0002, 1'b0, 1'b1},
            '{32'h4020_0000, 1'b1, 32'h0000_0002, 1'b0, 1'b1},
            '{32'h4060_0000, 1'b1, 32'h0000_0004, 1'b0, 1'b1},
            '{32'hC000_0000, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{32'hBFC0_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1},
            '{32'hC020_0000, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1},
            '{32'h4E80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0},
            '{32'h4EFF_FFFF, 1'b1, 32'h7FFF_FF80, 1'b0, 1'b0},
            '{32'h4B7F_FFFF, 1'b1, 32'h00FF_FFFF, 1'b0, 1'b0},
            '{32'h4F32_D05E, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0},
            '{32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0},
            '{32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0},
            '{32'hCF00_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0},
            '{32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0},
            '{32'hFFC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0},
            '{32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0},
            '{32'h3F00_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1},
            '{32'h3F40_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b1},
            '{32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b1},
            '{32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0},
            '{32'h3F80_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0}
        };
        for (int i = 0; i < 22; i++) begin
            sb.push_back('{tbl[i].q, tbl[i].inv, tbl[i].inx});
            xfer(tbl[i].din, tbl[i].rm, lat);
            ex = sb.pop_front();
            checks++; if (lat != exp_lat(tbl[i].din, 8)) begin
                errors++; $display("FAIL latency in=%h got=%0d want=%0d", tbl[i].din, lat, exp_lat(tbl[i].din, 8));
            end
            checks++; if (got_d !== ex.d) begin
                errors++; $display("FAIL data in=%h rm=%b got=%h want=%h", tbl[i].din, tbl[i].rm, got_d, ex.d);
            end
            checks++; if ({got_i, got_x} !== {ex.inv, ex.inx}) begin
                errors++; $display("FAIL flags in=%h got inv/inx=%b%b want=%b%b", tbl[i].din, got_i, got_x, ex.inv, ex.inx);
            end
            checks++; if (ir !== 1'b1 || ov !== 1'b0) begin
                errors++; $display("FAIL drain in=%h in_ready=%b out_valid=%b want 1/0", tbl[i].din, ir, ov);
            end
        end
    endtask

    task automatic test_step1();
        exp_t ex;
        int lat;
        sel = 1'b1;
        sb.push_back('{32'h0000_0001, 1'b0, 1'b0});
        xfer(32'h3F80_0000, 1'b0, lat);
        ex = sb.pop_front();
        checks++; if (lat != 24) begin errors++; $display("FAIL step1_latency got=%0d want=24", lat); end
        checks++; if (got_d !== ex.d || {got_i, got_x} !== {ex.inv, ex.inx}) begin
            errors++; $display("FAIL step1_result got=%h %b%b want=%h %b%b", got_d, got_i, got_x, ex.d, ex.inv, ex.inx);
        end
        sb.push_back('{32'hFFFF_FFFE, 1'b0, 1'b1});
        xfer(32'hBFC0_0000, 1'b1, lat);
        ex = sb.pop_front();
        checks++; if (got_d !== ex.d || {got_i, got_x} !== {ex.inv, ex.inx}) begin
            errors++; $display("FAIL step1_round got=%h %b%b want=%h %b%b", got_d, got_i, got_x, ex.d, ex.inv, ex.inx);
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t ex;
        int lat, bad, extra;
        sb.push_back('{32'h0000_0002, 1'b0, 1'b1});
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'h4020_0000; round_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!ov && lat < 200) begin @(posedge clk); #1; lat++; end
        ex = sb.pop_front();
        checks++; if (lat >= 200) begin errors++; $display("FAIL bp_timeout got=%0d cycles want<200", lat); end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                @(negedge clk);
                in_data = 32'h4000_0000; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (ov !== 1'b1 || ir !== 1'b0 || od !== ex.d || {oi, ox} !== {ex.inv, ex.inx}) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles want=0", bad); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", ov, ir);
        end
        checks++; if (od !== ex.d) begin errors++; $display("FAIL bp_retain got=%h want=%h", od, ex.d); end
        extra = 0;
        repeat (10) begin @(posedge clk); #1; if (ov) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL bp_ignored_input got=%0d valid cycles want=0", extra); end
    endtask

    initial begin
        test_reset();
        test_values();
        test_step1();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
